// File: rtl/seg_scan_display_if.sv
// Display bus between the upstream DHT-11 block and the seven-segment scanner:
// the display word, load strobe and flags go in; the anode and cathode drives come out.
interface seg_scan_display_if;
    logic [31:0] data_in;
    logic        load;
    logic [7:0]  dp_mask;
    logic        blink_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output data_in, load, dp_mask, blink_en,
        input  an, seg, dp
    );

    modport slave (
        input  data_in, load, dp_mask, blink_en,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 8-digit common-anode seven-segment scanner with a double-buffered
// BCD word, a blanking guard at the start of each digit slot, and alarm blinking.
//
// blink phase | meaning
// PH_ON       | anodes may be enabled
// PH_OFF      | all anodes forced off, scanning continues
module seg_scan_display #(
    parameter int CLK_HZ   = 100000000,
    parameter int SCAN_HZ  = 1000,
    parameter int GUARD    = 16,
    parameter int BLINK_HZ = 2
) (
    input logic              clk_in,
    input logic              rst,
    seg_scan_display_if.slave bus
);
    localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int SLOT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    phase_t             phase, phase_nxt;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [2:0]         digit_idx;
    logic [31:0]        shadow;
    logic [3:0]         nib;
    logic [6:0]         seg_nxt;
    logic [7:0]         an_nxt;
    logic               dp_nxt;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            phase     <= PH_ON;
            blink_cnt <= '0;
        end else begin
            phase     <= phase_nxt;
            blink_cnt <= blink_cnt_nxt;
        end
    end

    always_comb begin
        phase_nxt     = phase;
        blink_cnt_nxt = blink_cnt;
        if (!bus.blink_en) begin
            blink_cnt_nxt = '0;
            phase_nxt     = PH_ON;
        end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt_nxt = '0;
            phase_nxt     = (phase == PH_ON) ? PH_OFF : PH_ON;
        end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            shadow    <= 32'hFFFF_FFFF;
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            if (bus.load)
                shadow <= bus.data_in;
            if (slot_cnt == SLOT_W'(SCAN_DIV - 1)) begin
                slot_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    assign nib = shadow[{digit_idx, 2'b00} +: 4];

    always_comb begin
        seg_nxt = 7'h7F;
        case (nib)
            4'h0: seg_nxt = 7'b1000000;
            4'h1: seg_nxt = 7'b1111001;
            4'h2: seg_nxt = 7'b0100100;
            4'h3: seg_nxt = 7'b0110000;
            4'h4: seg_nxt = 7'b0011001;
            4'h5: seg_nxt = 7'b0010010;
            4'h6: seg_nxt = 7'b0000010;
            4'h7: seg_nxt = 7'b1111000;
            4'h8: seg_nxt = 7'b0000000;
            4'h9: seg_nxt = 7'b0010000;
            4'hA: seg_nxt = 7'b0001000;
            4'hB: seg_nxt = 7'b0000011;
            4'hC: seg_nxt = 7'b1000110;
            4'hD: seg_nxt = 7'b0100001;
            4'hE: seg_nxt = 7'b0000110;
            default: seg_nxt = 7'b1111111;
        endcase
    end

    // A blank digit still lights its anode when only its decimal point is wanted.
    always_comb begin
        an_nxt = 8'hFF;
        dp_nxt = ~bus.dp_mask[digit_idx];
        if ((slot_cnt >= SLOT_W'(GUARD)) && (phase == PH_ON) &&
            ((nib != 4'hF) || bus.dp_mask[digit_idx]))
            an_nxt[digit_idx] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            bus.an  <= 8'hFF;
            bus.seg <= 7'h7F;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_nxt;
            bus.seg <= seg_nxt;
            bus.dp  <= dp_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a shrunk clock: 10-cycle slots,
// 2-cycle guard, 50-cycle blink half-period.
module tb_seg_scan_display;
    localparam int CLK_HZ   = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int GUARD    = 2;
    localparam int BLINK_HZ = 10;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   n           = 0;

    seg_scan_display_if bus ();

    seg_scan_display #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .GUARD   (GUARD),
        .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    // n counts edges since the last reset edge; outputs after edge n show slot (n-1).
    task automatic step();
        logic r;
        r = rst;
        @(posedge clk_in);
        #1;
        if (r) n = 0;
        else   n = n + 1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_an"},  bus.an,  32'hFF);
        check_val({tag, "_seg"}, bus.seg, 32'h7F);
        check_val({tag, "_dp"},  bus.dp,  32'h1);
    endtask

    task automatic run_scan(input logic [7:0][6:0] es, input logic [7:0] vis,
                            input logic [7:0] m, input int n_last);
        int c, i;
        logic [7:0] e_an;
        logic       e_dp;
        while (n < n_last) begin
            step();
            c = (n - 1) % 10;
            i = ((n - 1) / 10) % 8;
            e_an = 8'hFF;
            if (c >= GUARD && vis[i]) e_an[i] = 1'b0;
            e_dp = ~m[i];
            check_val("scan_an",  bus.an,  e_an);
            check_val("scan_seg", bus.seg, es[i]);
            check_val("scan_dp",  bus.dp,  e_dp);
        end
    endtask

    task automatic start_with(input logic [31:0] d, input logic [7:0] m);
        logic e_dp;
        rst = 1'b1;
        step();
        check_reset_outs("rst");
        rst = 1'b0;
        bus.load    = 1'b1;
        bus.data_in = d;
        bus.dp_mask = m;
        step();
        bus.load = 1'b0;
        e_dp = ~m[0];
        check_val("first_an",  bus.an,  32'hFF);
        check_val("first_seg", bus.seg, 32'h7F);
        check_val("first_dp",  bus.dp,  e_dp);
    endtask

    logic [7:0][6:0] blank_seg;
    int   c, i;
    logic [7:0] e_an;
    logic on;

    initial begin
        bus.data_in  = 32'h0;
        bus.load     = 1'b0;
        bus.dp_mask  = 8'h00;
        bus.blink_en = 1'b0;
        blank_seg    = {8{7'h7F}};

        // idle after reset: everything dark
        rst = 1'b1;
        step();
        check_reset_outs("rst0");
        rst = 1'b0;
        run_scan(blank_seg, 8'h00, 8'h00, 200);

        // digits 0,1,4,5 lit
        start_with(32'hFF25_FF60, 8'h00);
        run_scan({7'h7F, 7'h7F, 7'h24, 7'h12, 7'h7F, 7'h7F, 7'h02, 7'h40}, 8'h33, 8'h00, 81);

        // remaining hex decodes: E d C A 9 7 3 1
        start_with(32'h1379_ACDE, 8'h00);
        run_scan({7'h79, 7'h30, 7'h78, 7'h10, 7'h08, 7'h46, 7'h21, 7'h06}, 8'hFF, 8'h00, 81);

        // blank digit 4 kept lit by its decimal point
        start_with(32'h86BF_F4F0, 8'h10);
        run_scan({7'h00, 7'h02, 7'h03, 7'h7F, 7'h7F, 7'h19, 7'h7F, 7'h40}, 8'hF5, 8'h10, 81);

        // load in the middle of digit 0's slot: segments change, slot keeps going
        bus.load    = 1'b1;
        bus.data_in = 32'h86BF_F4F1;
        step();
        bus.load = 1'b0;
        check_val("mid_old_seg", bus.seg, 32'h40);
        check_val("mid_old_an",  bus.an,  32'hFF);
        step();
        check_val("mid_new_seg", bus.seg, 32'h79);
        check_val("mid_new_an",  bus.an,  32'hFE);
        step();
        check_val("mid_hold_an", bus.an,  32'hFE);

        // blink: 50 visible, 50 dark, 50 visible, then drop blink_en while dark
        bus.blink_en = 1'b1;
        start_with(32'h8888_8888, 8'h00);
        while (n < 180) begin
            if (n == 160) bus.blink_en = 1'b0;
            step();
            c = (n - 1) % 10;
            i = ((n - 1) / 10) % 8;
            if (n <= 160) on = (((n - 1) / 50) % 2) == 0;
            else          on = (n >= 162);
            e_an = 8'hFF;
            if (c >= GUARD && on) e_an[i] = 1'b0;
            check_val("blink_an",  bus.an,  e_an);
            check_val("blink_seg", bus.seg, 32'h00);
        end

        // reset wins over a simultaneous load
        rst          = 1'b1;
        bus.load     = 1'b1;
        bus.data_in  = 32'h1234_5678;
        bus.dp_mask  = 8'h00;
        step();
        check_reset_outs("rst_load");
        rst      = 1'b0;
        bus.load = 1'b0;
        run_scan(blank_seg, 8'h00, 8'h00, 81);

        // reset mid-slot at index 5 restarts at index 0, counter 0
        bus.dp_mask = 8'h01;
        while (n < 55) step();
        check_val("pre_rst_an", bus.an, 32'hFF);
        rst = 1'b1;
        step();
        check_reset_outs("rst_mid");
        rst = 1'b0;
        run_scan(blank_seg, 8'h01, 8'h01, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
